// File: rtl/maxpool3x3s2_stream.sv
// 3x3, stride-2 streaming max-pool with ReLU folded in. One channel arrives as a
// raster-order stream of signed Q8.8 words; the pooled map leaves in raster order.
// A single row buffer holds per-column vertical maxima; a one-word accumulator
// merges three adjacent column maxima into each output.
module maxpool3x3s2_stream #(
  parameter int unsigned DW   = 16,
  parameter int unsigned IN_W = 111,
  parameter int unsigned IN_H = 111
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          frame_done
);

  localparam int unsigned OUT_W = (IN_W - 3) / 2 + 1;
  localparam int unsigned OUT_H = (IN_H - 3) / 2 + 1;
  localparam int unsigned CW    = $clog2(IN_W);
  localparam int unsigned RW    = $clog2(IN_H);

  typedef logic signed [DW-1:0] word_t;

  function automatic word_t smax(input word_t a, input word_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  word_t         hacc_q, hacc_d;
  word_t         colmax_q [IN_W];
  logic          out_valid_q, out_valid_d;
  word_t         out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic  accept;
  word_t x, cm, vmax, hmax;
  logic  last_col, last_row, row_even_ge2;

  // Stall upstream only while a held output word is blocked downstream.
  assign in_ready = !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready && !clear;

  assign x    = word_t'(in_data);
  assign cm   = colmax_q[col_q];
  assign vmax = smax(cm, x);
  assign hmax = smax(hacc_q, vmax);

  // For odd sizes the last index IN-1 equals 2*OUT.
  assign last_col     = (col_q == CW'(2 * OUT_W));
  assign last_row     = (row_q == RW'(2 * OUT_H));
  assign row_even_ge2 = (row_q != '0) && !row_q[0];

  // Next-state: raster counters, horizontal accumulator and output register.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hacc_d      = hacc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (clear) begin
      col_d       = '0;
      row_d       = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      // Even rows >= 2 complete a vertical window; vmax is that column's final max.
      if (row_even_ge2) begin
        if (col_q == '0) begin
          hacc_d = vmax;
        end else if (col_q[0]) begin
          hacc_d = hmax;
        end else begin
          // Column shared by adjacent windows seeds the next one.
          hacc_d      = vmax;
          out_valid_d = 1'b1;
          out_data_d  = hmax[DW-1] ? '0 : hmax;
          out_last_d  = last_row && last_col;
        end
      end
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      hacc_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      hacc_q      <= hacc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Row buffer: odd rows accumulate, row 0 and even rows restart with the new word.
  always_ff @(posedge clk) begin
    if (accept) begin
      colmax_q[col_q] <= row_q[0] ? vmax : x;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = out_valid_q && out_ready && out_last_q;

endmodule
